uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART byte transmitter among `N_REQ` requesters. It accepts one byte at a time from a winning requester and launches it into the transmitter with a one-cycle start pulse. It then waits for frame completion, enforces an inter-frame idle gap counted in baud ticks, and recovers from a hung transmitter with a watchdog. It sits between the client logic and the FSM-sequenced TX datapath (baud generator + PISO).

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_pick.sv | 33 +++
 rtl/uart_tx_sched.sv | 143 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_GAP_TICKS = 2;
    localparam int DEF_TIMEOUT   = 200000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request bit at or above ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any
);

    localparam int PW  = $clog2(N_REQ);
    localparam int PW1 = PW + 1;

    // One spare bit so ptr+i can exceed N_REQ-1 before the modulo fold.
    logic [PW:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + PW1'(i);
            if (idx >= PW1'(N_REQ)) begin
                idx = idx - PW1'(N_REQ);
            end
            if (!any && req[idx[PW-1:0]]) begin
                any    = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among N_REQ clients,
// with post-frame idle gap in baud ticks and a watchdog on hung frames.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int GAP_TICKS = DEF_GAP_TICKS,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [BYTE_W*N_REQ-1:0]   data,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          done,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_done,
    input  logic                      baud_tick,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int PW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam sched_state_t  AFTER_WAIT = (GAP_TICKS > 0) ? GAP : IDLE;

    sched_state_t      state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [BYTE_W-1:0] txd_q, txd_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              start_q, start_d;
    logic              terr_q, terr_d;
    logic [WW-1:0]     wd_q, wd_d;
    logic [GW-1:0]     gap_q, gap_d;

    logic [PW-1:0]     winner;
    logic              any;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            txd_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            terr_q  <= 1'b0;
            wd_q    <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            txd_q   <= txd_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            start_q <= start_d;
            terr_q  <= terr_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        txd_d   = txd_q;
        ack_d   = '0;
        done_d  = '0;
        start_d = 1'b0;
        terr_d  = 1'b0;
        wd_d    = wd_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    ack_d[winner] = 1'b1;
                    start_d       = 1'b1;
                    txd_d         = data[winner*BYTE_W +: BYTE_W];
                    owner_d       = winner;
                    if (winner == PW'(N_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = winner + 1'b1;
                    end
                    wd_d    = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A frame end on the expiry cycle counts as success.
                if (tx_done) begin
                    done_d[owner_q] = 1'b1;
                    gap_d           = '0;
                    state_d         = AFTER_WAIT;
                end else if (wd_q == WD_LAST) begin
                    terr_d  = 1'b1;
                    gap_d   = '0;
                    state_d = AFTER_WAIT;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            GAP: begin
                if (baud_tick) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign tx_start    = start_q;
    assign tx_data     = txd_q;
    assign owner       = owner_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a transaction-level reference model
// predicts grants, completions and watchdog aborts; a monitor checks them.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int GT = 2;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] data = '0;
    logic [N-1:0]   ack, done;
    logic           tx_start, busy, timeout_err;
    logic [7:0]     tx_data;
    logic           tx_done = 1'b0;
    logic           baud_tick = 1'b0;
    logic [1:0]     owner;

    int checks = 0;
    int errors = 0;

    typedef struct { int ow; logic [7:0] by; } gnt_t;
    gnt_t gq[$];
    int   dq[$];
    int   tq[$];
    gnt_t e;
    int   gl[8];

    uart_tx_sched #(.N_REQ(N), .GAP_TICKS(GT), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .data        (data),
        .ack         (ack),
        .done        (done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .baud_tick   (baud_tick),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            int k = (p + i) % N;
            if (((r >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    // Reference model: one byte transaction at a time, as a sequential program.
    initial begin : model
        int mptr, w, n, g;
        bit ab;
        mptr = 0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                mptr = 0;
                continue;
            end
            w = pick(req, mptr);
            if (w < 0) continue;
            gq.push_back('{ow: w, by: data[8*w +: 8]});
            mptr = (w + 1) % N;
            n  = 0;
            ab = 1'b0;
            forever begin
                @(posedge clk);
                if (!reset) begin ab = 1'b1; break; end
                n++;
                if (tx_done) begin dq.push_back(w); break; end
                if (n == TO) begin tq.push_back(1); break; end
            end
            g = 0;
            while (!ab && g < GT) begin
                @(posedge clk);
                if (!reset) ab = 1'b1;
                else if (baud_tick) g++;
            end
            if (ab) mptr = 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (tx_start || ack != 0 || gq.size() != 0) begin
                if (gq.size() == 0) begin
                    chk("unexpected grant", {27'd0, tx_start, ack}, 0);
                end else begin
                    e = gq.pop_front();
                    chk("tx_start", tx_start, 1);
                    chk("owner", owner, e.ow);
                    chk("tx_data", tx_data, e.by);
                    chk("ack", ack, 1 << e.ow);
                end
            end
            if (done != 0 || dq.size() != 0) begin
                if (dq.size() == 0) chk("unexpected done", done, 0);
                else chk("done", done, 1 << dq.pop_front());
            end
            if (timeout_err || tq.size() != 0) begin
                if (tq.size() == 0) chk("unexpected timeout_err", timeout_err, 0);
                else chk("timeout_err", timeout_err, tq.pop_front());
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_start) begin ok = 1'b1; return; end
        end
        checks++;
        errors++;
        $display("FAIL wait_grant: no tx_start within 60 cycles");
    endtask

    task automatic grab(input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_grant(ok);
            gl[i] = ok ? int'(owner) : -1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ack"}, ack, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " tx_start"}, tx_start, 0);
        chk({tag, " timeout_err"}, timeout_err, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " tx_data"}, tx_data, 0);
        chk({tag, " owner"}, owner, 0);
    endtask

    initial begin
        bit ok;
        int n;
        cyc(3);
        chk_all_zero("reset");
        reset = 1'b1;
        cyc(2);

        // single request from requester 2
        data[23:16] = 8'hA5;
        req = 4'b0100;
        wait_grant(ok);
        chk("t1 owner", owner, 2);
        chk("t1 tx_data", tx_data, 8'hA5);
        chk("t1 ack", ack, 4'b0100);
        req = '0;
        cyc(2);
        chk("t1 busy wait", busy, 1);
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        chk("t1 done", done, 4'b0100);
        chk("t1 busy gap", busy, 1);
        baud_tick = 1'b1;
        cyc(2);
        baud_tick = 1'b0;
        chk("t1 idle after gap", busy, 0);

        // rotation after serving 2
        req = 4'b1001;
        tx_done = 1'b1;
        baud_tick = 1'b1;
        grab(2);
        req = '0;
        chk("rot first", gl[0], 3);
        chk("rot second", gl[1], 0);
        cyc(6);
        tx_done = 1'b0;
        baud_tick = 1'b0;

        // all four held high from a fresh pointer
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        for (int i = 0; i < N; i++) data[8*i +: 8] = 8'($urandom);
        req = 4'b1111;
        tx_done = 1'b1;
        baud_tick = 1'b1;
        grab(6);
        req = '0;
        for (int i = 0; i < 6; i++) chk($sformatf("order[%0d]", i), gl[i], i % N);
        cyc(6);
        tx_done = 1'b0;
        baud_tick = 1'b0;

        // watchdog
        req = 4'b0001;
        wait_grant(ok);
        req = '0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (timeout_err) break;
        end
        chk("wd latency", n, TO);
        chk("wd busy gap", busy, 1);
        baud_tick = 1'b1;
        cyc(2);
        baud_tick = 1'b0;
        chk("wd idle", busy, 0);

        // tx_done on the expiry cycle
        req = 4'b0001;
        wait_grant(ok);
        req = '0;
        cyc(TO - 1);
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        chk("race done", done, 4'b0001);
        chk("race timeout_err", timeout_err, 0);
        baud_tick = 1'b1;
        cyc(2);
        baud_tick = 1'b0;

        // reset while waiting for frame end
        data[23:16] = 8'h3C;
        req = 4'b0100;
        wait_grant(ok);
        req = '0;
        cyc(3);
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        cyc(2);
        reset = 1'b1;
        req = 4'b0010;
        wait_grant(ok);
        chk("post-reset owner", owner, 1);
        req = '0;
        tx_done = 1'b1;
        baud_tick = 1'b1;
        cyc(4);
        req = 4'b0101;
        wait_grant(ok);
        chk("post-reset ptr", owner, 2);
        req = '0;
        cyc(6);
        tx_done = 1'b0;
        baud_tick = 1'b0;

        // randomized traffic, alternating prompt and hung transmitter phases
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (ack[i]) begin
                        if ($urandom_range(1) == 1) data[8*i +: 8] = 8'($urandom);
                        else req[i] = 1'b0;
                    end else if ($urandom_range(19) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                    data[8*i +: 8] = 8'($urandom);
                end
            end
            if (((c / 300) % 2) == 0) tx_done = ($urandom_range(4) == 0);
            else tx_done = ($urandom_range(59) == 0);
            baud_tick = ($urandom_range(2) == 0);
        end
        req = '0;
        tx_done = 1'b1;
        baud_tick = 1'b1;
        cyc(30);
        chk("queues drained", gq.size() + dq.size() + tq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
